negate_rr_sched: RTL and testbench
==================================

# negate_rr_sched

Round-robin scheduler that shares one registered bitwise-inversion datapath among `NREQ` requesters. Each requester presents a packed vector of `width` elements of type `DTYPE` through a valid/ready handshake. The block grants one requester per cycle, registers the inverted vector with the winner's index, and holds the result under downstream backpressure. It sits in front of the parameterized negation datapath and is the only path by which multiple clients reach it.

## Interface
- `NREQ`, default 4: number of requesters, 1..16.
- `width`, default 1: number of `DTYPE` elements per request.
- `DTYPE` (type parameter), default `logic`: element type; any packed type.
- `IDW` (localparam): `NREQ>1 ? $clog2(NREQ) : 1`.
- `DW` (localparam): `$bits(DTYPE)*width`.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: request i is presenting data.
- `req_data`  in  `DTYPE [NREQ-1:0][width-1:0]`: per-requester operand; slice i belongs to requester i.
- `req_ready`  out  NREQ: one-hot or zero; request i is accepted this cycle.
- `rsp_valid`  out  1: the result register holds a result.
- `rsp_ready`  in  1: downstream accepts the result.
- `rsp_data`  out  `DTYPE [width-1:0]`: `~req_data[winner]`, bitwise over all `DW` bits.
- `rsp_id`  out  IDW: index of the requester that produced `rsp_data`.
- `done_count`  out  16: count of completed responses; saturates.

## Operation
- State: result register (`rsp_valid`, `rsp_data`, `rsp_id`), round-robin pointer `ptr` (IDW bits, range 0..NREQ-1), and `done_count`.
- Slot free: `free = !rsp_valid || rsp_ready`.
- Arbitration (combinational):
  - The winner is the first i with `req_valid[i]`, scanning `ptr, ptr+1, …, NREQ-1, 0, …, ptr-1`.
  - `req_ready[i] = free && (i == winner) && !rst`.
  - No request valid means `req_ready = 0`.
- Accept, when `|(req_valid & req_ready)`. At the next edge:
  - `rsp_data <= ~req_data[winner]`
  - `rsp_id <= winner`
  - `rsp_valid <= 1`
  - `ptr <= (winner == NREQ-1) ? 0 : winner+1`
- Consume without accept (`rsp_valid && rsp_ready` and no accept): `rsp_valid <= 0`. `rsp_data` and `rsp_id` keep their last values.
- Consume and accept in the same cycle: the new result replaces the old one, `rsp_valid` stays 1, and there is no bubble.
- Hold (`rsp_valid && !rsp_ready`): `rsp_data`, `rsp_id` and `ptr` are stable, and all `req_ready` are 0.
- `ptr` changes only on accept, never on idle cycles.
- `done_count` increments on every `rsp_valid && rsp_ready` and saturates at 16'hFFFF.
- With `NREQ == 1`: `ptr` is constantly 0 and the block degenerates to a one-entry pipe.
- Requesters may drop `req_valid` without being granted. The block imposes no stickiness.

## Timing
- Reset (async assert, synchronous-safe release): `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `ptr=0`, `done_count=0`. `req_ready=0` while `rst` is high.
- Latency: data accepted at edge N appears with `rsp_valid=1` after edge N.
- Throughput: one result per cycle while `rsp_ready=1`.
- `req_ready` depends combinationally on `req_valid`, `rsp_ready` and state. `rsp_*` outputs are registered only.
- Reset mid-operation: any pending result is dropped, with no `done_count` increment for it. The first grant after release goes to the lowest valid index.
- Fairness: a continuously valid requester is granted within NREQ accepts.

## Test plan
All scenarios use NREQ=4, width=4, DTYPE=`logic [3:0]`.
- **Reset:** assert `rst` mid-stream with `rsp_valid=1`. Required response: `rsp_valid`, `rsp_data`, `rsp_id`, `done_count`, `req_ready` all read 0 immediately (asynchronously).
- **Single request:** only requester 2 is valid with data 16'h1234. Required response: `req_ready=4'b0100` that cycle, then `rsp_valid=1`, `rsp_data=16'hEDCB`, `rsp_id=2`, and `done_count=1` after the consume.
- **Full load:** all four requesters valid, `rsp_ready=1`. Required response: grants 0,1,2,3,0,1 on consecutive cycles, and `rsp_valid` continuously 1 from the second cycle.
- **Backpressure:** `rsp_ready=0` while `rsp_valid=1` for 5 cycles. Required response: `req_ready=0` throughout and `rsp_data`/`rsp_id` unchanged. On the cycle `rsp_ready` rises, a new grant occurs in that same cycle with no bubble.
- **Wrap-around priority:** the last grant went to 3, then requesters 0 and 3 are both valid. Required response: 0 wins; on the next cycle 3 wins over a re-asserted 0.
- **Counter saturation:** preload `done_count` to 16'hFFFE via force, then complete 3 responses. Required response: `done_count` reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/negate_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : negate_rr_sched
//  Description : Round-robin scheduler sharing one registered bitwise-inversion
//                datapath among NREQ valid/ready requesters. The winner's
//                inverted vector and index are held in a result register
//                under downstream backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module negate_rr_sched #(
    parameter int  NREQ  = 4,
    parameter int  width = 1,
    parameter type DTYPE = logic,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int DW    = $bits(DTYPE) * width
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  DTYPE [NREQ-1:0][width-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output DTYPE [width-1:0]           rsp_data,
    output logic [IDW-1:0]             rsp_id,
    output logic [15:0]                done_count
);

    logic             r_rsp_valid;
    logic [DW-1:0]    r_rsp_data;
    logic [IDW-1:0]   r_rsp_id;
    logic [IDW-1:0]   r_ptr;
    logic [15:0]      r_done_count;

    logic             w_free;
    logic             w_any;
    logic             w_accept;
    logic             w_consume;
    logic [IDW-1:0]   w_winner;
    logic [DW-1:0]    w_inv;
    int               w_idx;

    // The slot can take a new result when empty or being drained this cycle.
    assign w_free    = !r_rsp_valid || rsp_ready;
    assign w_consume = r_rsp_valid && rsp_ready;
    assign w_accept  = w_free && w_any && !rst;
    assign w_inv     = ~req_data[w_winner];

    // Rotating priority scan: iterate from the farthest offset back to ptr so
    // the valid requester closest to ptr (in wrap order) is the final winner.
    always_comb begin
        w_winner = '0;
        w_any    = 1'b0;
        w_idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (req_valid[w_idx]) begin
                w_winner = IDW'(w_idx);
                w_any    = 1'b1;
            end
        end
    end

    // One-hot grant to the winner, only when the result slot can take it.
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    // Result register and round-robin pointer; accept overrides consume so a
    // simultaneous drain and refill leaves no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_ptr       <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_inv;
            r_rsp_id    <= w_winner;
            r_ptr       <= (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
        end else if (w_consume) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Saturating count of responses handed downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_count <= '0;
        end else if (w_consume && (r_done_count != 16'hFFFF)) begin
            r_done_count <= r_done_count + 16'd1;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;
    assign done_count = r_done_count;

endmodule
`default_nettype wire

// File: tb/tb_negate_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_negate_rr_sched
//  Description : Scoreboard bench for negate_rr_sched (NREQ=4, width=4,
//                DTYPE=logic[3:0]). Directed stimulus pushes hand-computed
//                {id,data} expectations; a monitor pops on every consume.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_negate_rr_sched;

    logic                   clk;
    logic                   rst;
    logic [3:0]             req_valid;
    logic [3:0][3:0][3:0]   req_data;
    logic [3:0]             req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [3:0][3:0]        rsp_data;
    logic [1:0]             rsp_id;
    logic [15:0]            done_count;

    int                     n_tests;
    int                     n_fail;
    logic [17:0]            sb_q[$];

    negate_rr_sched #(
        .NREQ  (4),
        .width (4),
        .DTYPE (logic [3:0])
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic to_drv();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    // Monitor: every consume handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got id=%0d data=%h, required no response",
                         rsp_id, rsp_data);
            end else begin
                chk("sb_rsp", {14'd0, rsp_id, rsp_data}, {14'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        logic [15:0] exp_inv [4];
        logic [1:0]  gid;
        n_tests   = 0;
        n_fail    = 0;
        // Inversions of 1111/2222/3333/4444 for requesters 0..3.
        exp_inv   = '{16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB};
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        req_data  = '0;

        // ---- reset state ----
        to_neg();
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_done", {16'd0, done_count}, 32'd0);
        to_drv();
        to_drv();
        rst       = 1'b0;
        req_valid = 4'b0000;

        // ---- single request ----
        req_valid   = 4'b0100;
        req_data[2] = 16'h1234;
        rsp_ready   = 1'b1;
        to_neg();
        chk("single_ready", {28'd0, req_ready}, 32'h4);
        sb_q.push_back({2'd2, 16'hEDCB});
        to_drv();
        req_valid = 4'b0000;
        to_neg();
        chk("single_valid", {31'd0, rsp_valid}, 32'd1);
        to_drv();
        to_neg();
        chk("single_done", {16'd0, done_count}, 32'd1);
        chk("single_drained", {31'd0, rsp_valid}, 32'd0);

        // ---- wrap-around priority (ptr=3 after granting 2) ----
        req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        to_drv();
        req_valid = 4'b1000;
        to_neg();
        chk("wrap_g3", {28'd0, req_ready}, 32'h8);
        sb_q.push_back({2'd3, 16'hBBBB});
        to_drv();
        req_valid = 4'b1001;
        to_neg();
        chk("wrap_g0", {28'd0, req_ready}, 32'h1);
        sb_q.push_back({2'd0, 16'hEEEE});
        to_drv();
        to_neg();
        chk("wrap_g3_again", {28'd0, req_ready}, 32'h8);
        sb_q.push_back({2'd3, 16'hBBBB});
        to_drv();
        req_valid = 4'b0000;
        to_neg();
        to_drv();
        to_neg();
        chk("wrap_done", {16'd0, done_count}, 32'd4);

        // ---- full load (ptr=0): grants 0,1,2,3,0,1 ----
        to_drv();
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            gid = 2'(c % 4);
            to_neg();
            chk("full_grant", {28'd0, req_ready}, 32'(1 << gid));
            sb_q.push_back({gid, exp_inv[gid]});
            if (c > 0) chk("full_valid", {31'd0, rsp_valid}, 32'd1);
            to_drv();
        end
        req_valid = 4'b0000;
        to_neg();
        chk("full_valid_tail", {31'd0, rsp_valid}, 32'd1);
        to_drv();
        to_neg();
        chk("full_drained", {31'd0, rsp_valid}, 32'd0);
        chk("full_done", {16'd0, done_count}, 32'd10);

        // ---- backpressure (ptr=2) ----
        to_drv();
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        to_neg();
        chk("bp_grant", {28'd0, req_ready}, 32'h4);
        sb_q.push_back({2'd2, 16'hCCCC});
        for (int c = 0; c < 5; c++) begin
            to_drv();
            req_valid = 4'b0001;
            to_neg();
            chk("bp_ready0", {28'd0, req_ready}, 32'd0);
            chk("bp_hold", {14'd0, rsp_id, rsp_data}, {14'd0, 2'd2, 16'hCCCC});
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
        end
        to_drv();
        rsp_ready = 1'b1;
        to_neg();
        chk("bp_release_grant", {28'd0, req_ready}, 32'h1);
        sb_q.push_back({2'd0, 16'hEEEE});
        to_drv();
        req_valid = 4'b0000;
        to_neg();
        chk("bp_no_bubble", {31'd0, rsp_valid}, 32'd1);
        to_drv();
        to_neg();
        chk("bp_done", {16'd0, done_count}, 32'd12);

        // ---- reset mid-stream (ptr=1 -> grant 2 -> ptr=3, then reset) ----
        to_drv();
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        to_neg();
        chk("mr_grant", {28'd0, req_ready}, 32'h4);
        to_drv();
        req_valid = 4'b1111;
        to_neg();
        chk("mr_pending", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mr_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("mr_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("mr_done", {16'd0, done_count}, 32'd0);
        chk("mr_req_ready", {28'd0, req_ready}, 32'd0);
        to_drv();
        rst       = 1'b0;
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        to_neg();
        chk("mr_lowest_first", {28'd0, req_ready}, 32'h2);
        sb_q.push_back({2'd1, 16'hDDDD});
        to_drv();
        req_valid = 4'b0000;
        to_neg();
        to_drv();
        to_neg();
        chk("mr_done_after", {16'd0, done_count}, 32'd1);

        // ---- counter saturation ----
        to_drv();
        force dut.r_done_count = 16'hFFFE;
        #1;
        release dut.r_done_count;
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            to_neg();
            chk("sat_grant", {28'd0, req_ready}, 32'h4);
            sb_q.push_back({2'd2, 16'hCCCC});
            to_drv();
        end
        req_valid = 4'b0000;
        to_neg();
        to_drv();
        to_neg();
        chk("sat_done", {16'd0, done_count}, 32'hFFFF);
        to_drv();
        to_neg();
        chk("sat_done_hold", {16'd0, done_count}, 32'hFFFF);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
